ppu_bg_fetch_unit: RTL and testbench

Background fetch responder and pixel pipeline for the PPU. Executes each fetch phase the background rendering FSM announces (NT, AT, BG_Lsb, BG_Msb): it generates the VRAM address, issues the read, latches the returned byte, loads the tile shift registers and emits one 4-bit background palette index per pixel tick. It sits between the rendering FSM, the scroll (v) register unit and the PPU VRAM bus.

---
 rtl/ppu_defs.sv | 22 ++
 rtl/ppu_bg_shifter.sv | 53 +++++
 rtl/ppu_bg_fetch_unit.sv | 98 +++++++++
 tb/tb_ppu_bg_fetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ppu_defs.sv
// Shared PPU definitions: background fetch state codes, VRAM base addresses, phase length.
package ppu_defs;

  localparam int          PHASE_LEN = 8;
  localparam logic [13:0] NT_BASE   = 14'h2000;
  localparam logic [13:0] AT_BASE   = 14'h23C0;

  typedef enum logic [2:0] {
    FS_SLEEP  = 3'd0,
    FS_IDLE   = 3'd1,
    FS_NT     = 3'd2,
    FS_AT     = 3'd3,
    FS_BG_LSB = 3'd4,
    FS_BG_MSB = 3'd5,
    FS_VBLANK = 3'd6
  } fetch_state_t;

  function automatic logic is_fetch(input logic [2:0] s);
    return (s >= 3'd2) && (s <= 3'd5);
  endfunction

endpackage

// File: rtl/ppu_bg_shifter.sv
// Background tile/attribute shift registers with fine-X pixel select.
module ppu_bg_shifter
  import ppu_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  input  logic [1:0] at,
  input  logic [2:0] fine_x,
  output logic [3:0] pixel
);

  logic [15:0] pt_lo, pt_hi;
  logic [7:0]  at_lo, at_hi;
  logic        feed_lo, feed_hi;

  // ~fine_x == 7-fine_x for a 3-bit value
  logic [2:0] at_idx;
  logic [3:0] pt_idx;
  assign at_idx = ~fine_x;
  assign pt_idx = {1'b1, ~fine_x};

  always_ff @(posedge clk) begin
    if (rst) begin
      pt_lo   <= '0;
      pt_hi   <= '0;
      at_lo   <= '0;
      at_hi   <= '0;
      feed_lo <= 1'b0;
      feed_hi <= 1'b0;
      pixel   <= '0;
    end else begin
      if (shift) begin
        pt_lo <= {pt_lo[14:0], 1'b0};
        pt_hi <= {pt_hi[14:0], 1'b0};
        at_lo <= {at_lo[6:0], feed_lo};
        at_hi <= {at_hi[6:0], feed_hi};
        pixel <= {at_hi[at_idx], at_lo[at_idx], pt_hi[pt_idx], pt_lo[pt_idx]};
      end
      // Placed after the shift so a coincident load owns the low byte.
      if (load) begin
        pt_lo[7:0] <= lo;
        pt_hi[7:0] <= hi;
        feed_lo    <= at[0];
        feed_hi    <= at[1];
      end
    end
  end

endmodule

// File: rtl/ppu_bg_fetch_unit.sv
// Background fetch responder: phase tracking, VRAM address generation, fetch latches.
module ppu_bg_fetch_unit
  import ppu_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  fetch_state,
  input  logic        step,
  input  logic        pixel_en,
  input  logic [14:0] v_addr,
  input  logic        bg_pattern_sel,
  input  logic [2:0]  fine_x,
  input  logic [7:0]  vram_rdata,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  output logic [3:0]  bg_pixel,
  output logic        incx_req
);

  fetch_state_t fs;
  assign fs = fetch_state_t'(fetch_state);

  logic [2:0]  prev_state;
  logic        prev_step;
  logic [7:0]  nt_latch, lo_latch;
  logic [1:0]  at_latch, at_field;
  logic [13:0] addr_nxt;
  logic        phase_start, load;

  // A repeated state code still starts a new phase if the previous one just stepped.
  assign phase_start = is_fetch(fetch_state) && ((fetch_state != prev_state) || prev_step);
  assign load        = step && (fs == FS_BG_MSB);

  always_comb begin
    addr_nxt = vram_addr;
    case (fs)
      FS_NT:     addr_nxt = NT_BASE | {2'b00, v_addr[11:0]};
      FS_AT:     addr_nxt = AT_BASE | {2'b00, v_addr[11:10], 10'b0}
                                    | {8'b0, v_addr[9:7], 3'b0}
                                    | {11'b0, v_addr[4:2]};
      FS_BG_LSB: addr_nxt = {1'b0, bg_pattern_sel, nt_latch, 1'b0, v_addr[14:12]};
      FS_BG_MSB: addr_nxt = {1'b0, bg_pattern_sel, nt_latch, 1'b1, v_addr[14:12]};
      default:   ;
    endcase
  end

  // Attribute quadrant within the 32x32 block: {coarse_y[1], coarse_x[1]}.
  always_comb begin
    at_field = 2'b00;
    case ({v_addr[6], v_addr[1]})
      2'b00: at_field = vram_rdata[1:0];
      2'b01: at_field = vram_rdata[3:2];
      2'b10: at_field = vram_rdata[5:4];
      2'b11: at_field = vram_rdata[7:6];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state <= '0;
      prev_step  <= 1'b0;
      vram_addr  <= '0;
      vram_rd    <= 1'b0;
      incx_req   <= 1'b0;
      nt_latch   <= '0;
      lo_latch   <= '0;
      at_latch   <= '0;
    end else begin
      prev_state <= fetch_state;
      prev_step  <= step;
      vram_rd    <= phase_start;
      incx_req   <= load;
      if (phase_start) vram_addr <= addr_nxt;
      if (step) begin
        case (fs)
          FS_NT:     nt_latch <= vram_rdata;
          FS_AT:     at_latch <= at_field;
          FS_BG_LSB: lo_latch <= vram_rdata;
          default:   ;
        endcase
      end
    end
  end

  ppu_bg_shifter u_shifter (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .shift  (pixel_en),
    .lo     (lo_latch),
    .hi     (vram_rdata),
    .at     (at_latch),
    .fine_x (fine_x),
    .pixel  (bg_pixel)
  );

endmodule

// File: tb/tb_ppu_bg_fetch_unit.sv
// Directed bench for ppu_bg_fetch_unit: fetch addresses, strobes, pixel output, reset abort.
module tb_ppu_bg_fetch_unit;
  import ppu_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  fetch_state;
  logic        step;
  logic        pixel_en;
  logic [14:0] v_addr;
  logic        bg_pattern_sel;
  logic [2:0]  fine_x;
  logic [7:0]  vram_rdata;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic [3:0]  bg_pixel;
  logic        incx_req;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ppu_bg_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_state    (fetch_state),
    .step           (step),
    .pixel_en       (pixel_en),
    .v_addr         (v_addr),
    .bg_pattern_sel (bg_pattern_sel),
    .fine_x         (fine_x),
    .vram_rdata     (vram_rdata),
    .vram_addr      (vram_addr),
    .vram_rd        (vram_rd),
    .bg_pixel       (bg_pixel),
    .incx_req       (incx_req)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one phase of ncyc clocks; step only on the last clock of a full phase.
  task automatic run_phase(input logic [2:0] s, input logic [7:0] rdata, input int ncyc,
                           output logic [13:0] addr, output int rd_cnt, output int rd_pos,
                           output int incx_cnt);
    fetch_state = s;
    vram_rdata  = rdata;
    addr = '0; rd_cnt = 0; rd_pos = -1; incx_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      step = (i == PHASE_LEN - 1);
      tick();
      if (vram_rd) begin
        rd_cnt++;
        addr   = vram_addr;
        rd_pos = i;
      end
      if (incx_req) incx_cnt++;
    end
    step = 1'b0;
  endtask

  task automatic pixel_tick();
    pixel_en = 1'b1;
    tick();
    pixel_en = 1'b0;
    tick(); tick(); tick();
  endtask

  logic [13:0] a;
  int rc, rp, ic, ic2, rp2, rc_tot, ic_tot;
  logic [3:0] exp_seq [8];

  initial begin
    rst = 1'b1; fetch_state = FS_SLEEP; step = 1'b0; pixel_en = 1'b0;
    v_addr = '0; bg_pattern_sel = 1'b0; fine_x = '0; vram_rdata = '0;
    tick(); tick();
    check("rst_addr",  32'(vram_addr), 32'h0);
    check("rst_rd",    32'(vram_rd),   32'h0);
    check("rst_incx",  32'(incx_req),  32'h0);
    check("rst_pixel", 32'(bg_pixel),  32'h0);
    rst = 1'b0;
    tick();

    // Full fetch sequence at v=0, pattern table 0
    run_phase(FS_NT, 8'h42, 8, a, rc, rp, ic);
    check("A_nt_addr", 32'(a), 32'h2000);  check("A_nt_rdcnt", rc, 1);
    run_phase(FS_AT, 8'hE4, 8, a, rc, rp, ic);
    check("A_at_addr", 32'(a), 32'h23C0);  check("A_at_rdcnt", rc, 1);
    run_phase(FS_BG_LSB, 8'hA5, 8, a, rc, rp, ic);
    check("A_lsb_addr", 32'(a), 32'h0420); check("A_lsb_rdcnt", rc, 1);
    run_phase(FS_BG_MSB, 8'hFF, 8, a, rc, rp, ic);
    check("A_msb_addr", 32'(a), 32'h0428); check("A_msb_rdcnt", rc, 1);
    check("A_incx_cnt", ic, 1);

    // Pattern table 1, fine y 3
    v_addr = 15'h3000; bg_pattern_sel = 1'b1;
    run_phase(FS_NT, 8'h42, 8, a, rc, rp, ic);
    run_phase(FS_BG_LSB, 8'h00, 8, a, rc, rp, ic);
    check("B_lsb_addr", 32'(a), 32'h1423);
    run_phase(FS_BG_MSB, 8'h00, 8, a, rc, rp, ic);
    check("B_msb_addr", 32'(a), 32'h142B);

    // Attribute quadrant 01 -> 2'b01, observed through fine_x=7 after two shifts
    v_addr = 15'h0802;
    run_phase(FS_AT, 8'hE4, 8, a, rc, rp, ic);
    check("C_at_addr", 32'(a), 32'h2BC0);
    run_phase(FS_BG_LSB, 8'hA5, 8, a, rc, rp, ic);
    run_phase(FS_BG_MSB, 8'hFF, 8, a, rc, rp, ic);
    fine_x = 3'd7;
    pixel_tick(); pixel_tick();
    check("C_pixel_q01", 32'(bg_pixel), 32'h7);

    // Quadrant 11 -> 2'b11
    v_addr = 15'h0842;
    run_phase(FS_AT, 8'hE4, 8, a, rc, rp, ic);
    check("D_at_addr", 32'(a), 32'h2BC0);
    run_phase(FS_BG_LSB, 8'hA5, 8, a, rc, rp, ic);
    run_phase(FS_BG_MSB, 8'hFF, 8, a, rc, rp, ic);
    pixel_tick(); pixel_tick();
    check("D_pixel_q11", 32'(bg_pixel), 32'hF);

    // lo=A5 hi=FF attr=2 fine_x=0: tile reaches the output after 8 shifts
    v_addr = 15'h0040; fine_x = 3'd0;
    run_phase(FS_AT, 8'hE4, 8, a, rc, rp, ic);
    check("E_at_addr", 32'(a), 32'h23C0);
    run_phase(FS_BG_LSB, 8'hA5, 8, a, rc, rp, ic);
    run_phase(FS_BG_MSB, 8'hFF, 8, a, rc, rp, ic);
    for (int i = 0; i < 8; i++) pixel_tick();
    exp_seq = '{4'hB, 4'hA, 4'hB, 4'hA, 4'hA, 4'hB, 4'hA, 4'hB};
    for (int i = 0; i < 8; i++) begin
      pixel_tick();
      check($sformatf("E_pixel%0d", i), 32'(bg_pixel), 32'(exp_seq[i]));
    end

    // NT -> NT across a step: two reads 8 clocks apart, no coarse-X increment
    fetch_state = FS_IDLE; tick();
    run_phase(FS_NT, 8'h10, 8, a, rc, rp, ic);
    run_phase(FS_NT, 8'h11, 8, a, rc, rp2, ic2);
    check("F_rd_pos1", rp, 0);
    check("F_rd_pos2", rp2, 0);
    check("F_incx", ic + ic2, 0);

    // Reset at cycle 3 of BG_Msb aborts the load
    run_phase(FS_BG_LSB, 8'h5A, 8, a, rc, rp, ic);
    run_phase(FS_BG_MSB, 8'hC3, 3, a, rc, rp, ic);
    rst = 1'b1; fetch_state = FS_SLEEP;
    tick();
    check("G_rst_addr",  32'(vram_addr), 32'h0);
    check("G_rst_rd",    32'(vram_rd),   32'h0);
    check("G_rst_incx",  32'(incx_req),  32'h0);
    check("G_rst_pixel", 32'(bg_pixel),  32'h0);
    rst = 1'b0;
    rc_tot = 0; ic_tot = 0;
    for (int i = 0; i < 10; i++) begin
      step = (i == 4);
      tick();
      if (vram_rd) rc_tot++;
      if (incx_req) ic_tot++;
    end
    step = 1'b0;
    check("G_no_rd",   rc_tot, 0);
    check("G_no_incx", ic_tot, 0);
    fine_x = 3'd7;
    pixel_tick(); pixel_tick();
    check("G_no_load_pixel", 32'(bg_pixel), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
